urv_irq_ctrl: RTL

- External interrupt controller that aggregates up to 32 peripheral interrupt lines into the single exp_irq request consumed by the core's exception unit.
- Per-line enable, edge/level selection and pending latch, plus a lowest-index-wins claim register.
- Memory-mapped on the core data bus as a 4-word register window.
- Sits directly upstream of the exception unit: irq_o drives exp_irq_i.

---
 rtl/urv_irq_pkg.sv | 16 +
 rtl/urv_irq_prio_enc.sv | 24 ++
 rtl/urv_irq_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/urv_irq_pkg.sv
// Shared definitions for the urv external interrupt controller: register map,
// CLAIM word layout and line-count limits.
package urv_irq_pkg;

    typedef enum logic [1:0] {
        URV_IRQ_REG_PENDING = 2'd0,
        URV_IRQ_REG_ENABLE  = 2'd1,
        URV_IRQ_REG_EDGE    = 2'd2,
        URV_IRQ_REG_CLAIM   = 2'd3
    } urv_irq_reg_e;

    localparam int unsigned URV_IRQ_CLAIM_VALID_BIT = 31;
    localparam int unsigned URV_IRQ_MAX_LINES       = 32;
    localparam int unsigned URV_IRQ_ID_W            = 5;

endpackage

// File: rtl/urv_irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and
// the index of the lowest set request (0 when none).
module urv_irq_prio_enc
    import urv_irq_pkg::*;
#(
    parameter int unsigned g_num_irqs = 8
) (
    input  logic [g_num_irqs-1:0]   req,
    output logic                    valid,
    output logic [URV_IRQ_ID_W-1:0] id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int unsigned i = 0; i < g_num_irqs; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                id    = URV_IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/urv_irq_ctrl.sv
// urv external interrupt controller: per-line enable/edge/pending, lowest-index
// claim register, 4-word bus window. Define URV_IRQ_SYNC_EN for a 2-flop input synchroniser.
module urv_irq_ctrl
    import urv_irq_pkg::*;
#(
    parameter int unsigned g_num_irqs = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [g_num_irqs-1:0] irq_lines_i,
    input  logic [1:0]            bus_addr_i,
    input  logic                  bus_wr_i,
    input  logic                  bus_rd_i,
    input  logic [31:0]           bus_wdata_i,
    output logic [31:0]           bus_rdata_o,
    output logic                  bus_ack_o,
    output logic                  irq_o,
    output logic [4:0]            irq_id_o
);

    logic [g_num_irqs-1:0]   sample_in;
    logic [g_num_irqs-1:0]   sample;
    logic [g_num_irqs-1:0]   prev;
    logic [g_num_irqs-1:0]   pending;
    logic [g_num_irqs-1:0]   pending_next;
    logic [g_num_irqs-1:0]   enable;
    logic [g_num_irqs-1:0]   edge_sel;
    logic [g_num_irqs-1:0]   active;
    logic [g_num_irqs-1:0]   rise;
    logic [g_num_irqs-1:0]   clr;
    logic                    claim_valid;
    logic [URV_IRQ_ID_W-1:0] claim_id;
    logic [31:0]             read_val;
    logic                    unused_wdata;

    assign unused_wdata = ^bus_wdata_i;

`ifdef URV_IRQ_SYNC_EN
    // The sample register doubles as the second synchroniser flop, so the
    // synchroniser costs only one extra cycle of latency.
    logic [g_num_irqs-1:0] sync_meta;

    always_ff @(posedge clk_i) begin
        if (!rst_i) sync_meta <= '0;
        else        sync_meta <= irq_lines_i;
    end

    assign sample_in = sync_meta;
`else
    assign sample_in = irq_lines_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sample <= '0;
            prev   <= '0;
        end else begin
            sample <= sample_in;
            prev   <= sample;
        end
    end

    assign rise   = sample & ~prev;
    assign active = pending & enable;

    // Clear requests from W1C on PENDING and from CLAIM writes; ids beyond the
    // implemented lines match no bit and are ignored.
    always_comb begin
        clr = '0;
        if (bus_wr_i) begin
            case (urv_irq_reg_e'(bus_addr_i))
                URV_IRQ_REG_PENDING: clr = bus_wdata_i[g_num_irqs-1:0];
                URV_IRQ_REG_CLAIM: begin
                    for (int unsigned i = 0; i < g_num_irqs; i++)
                        clr[i] = (bus_wdata_i[4:0] == 5'(i));
                end
                default: clr = '0;
            endcase
        end
    end

    // Edge lines: a new rise beats a same-cycle clear. Level lines track the sample.
    assign pending_next = (edge_sel & ((pending & ~clr) | rise)) | (~edge_sel & sample);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pending  <= '0;
            enable   <= '0;
            edge_sel <= '0;
        end else begin
            pending <= pending_next;
            if (bus_wr_i && urv_irq_reg_e'(bus_addr_i) == URV_IRQ_REG_ENABLE)
                enable <= bus_wdata_i[g_num_irqs-1:0];
            if (bus_wr_i && urv_irq_reg_e'(bus_addr_i) == URV_IRQ_REG_EDGE)
                edge_sel <= bus_wdata_i[g_num_irqs-1:0];
        end
    end

    urv_irq_prio_enc #(
        .g_num_irqs(g_num_irqs)
    ) u_prio_enc (
        .req  (active),
        .valid(claim_valid),
        .id   (claim_id)
    );

    always_comb begin
        read_val = '0;
        case (urv_irq_reg_e'(bus_addr_i))
            URV_IRQ_REG_PENDING: read_val[g_num_irqs-1:0] = pending;
            URV_IRQ_REG_ENABLE:  read_val[g_num_irqs-1:0] = enable;
            URV_IRQ_REG_EDGE:    read_val[g_num_irqs-1:0] = edge_sel;
            URV_IRQ_REG_CLAIM: begin
                read_val[URV_IRQ_CLAIM_VALID_BIT]  = claim_valid;
                read_val[URV_IRQ_ID_W-1:0]         = claim_id;
            end
            default: read_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bus_ack_o   <= 1'b0;
            bus_rdata_o <= '0;
            irq_o       <= 1'b0;
            irq_id_o    <= '0;
        end else begin
            bus_ack_o   <= bus_rd_i | bus_wr_i;
            bus_rdata_o <= (bus_rd_i && !bus_wr_i) ? read_val : '0;
            irq_o       <= claim_valid;
            irq_id_o    <= claim_id;
        end
    end

endmodule
